// File: rtl/patch_kernel_loader.sv
// patch_kernel_loader: drains the host kernel FIFO into a local weight bank,
// then streams patch words tagged with their matching weight and index to
// the patch multiplier over valid/ready. A kernel arriving mid-stream is
// loaded at the next patch boundary, so a partial patch always finishes
// with the weights it started with.
module patch_kernel_loader #(
  parameter int DATA_W     = 32,
  parameter int KERNEL_LEN = 81,
  parameter int IDX_W      = 7,
  parameter int CNT_W      = 16
) (
  input  logic              bus_clk,
  input  logic              bus_rst,
  output logic              kernel_fifo_rd_en,
  input  logic [DATA_W-1:0] kernel_fifo_dout,
  input  logic              kernel_fifo_empty,
  output logic              patch_fifo_rd_en,
  input  logic [DATA_W-1:0] patch_fifo_dout,
  input  logic              patch_fifo_empty,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_patch,
  output logic [DATA_W-1:0] out_weight,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              kernel_loaded,
  output logic [CNT_W-1:0]  patch_count
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(KERNEL_LEN - 1);
  localparam logic [IDX_W-1:0] LEN_IDX  = IDX_W'(KERNEL_LEN);

  typedef enum logic {S_LOAD, S_STREAM} state_t;

  state_t state, state_next;

  // Kernel load path
  logic [DATA_W-1:0] bank [KERNEL_LEN];
  logic [IDX_W-1:0]  k_issued;   // kernel reads issued during this load
  logic [IDX_W-1:0]  kidx;       // next bank slot to write
  logic              k_rd_q;     // kernel word arrives this cycle

  // Patch stream path
  logic [IDX_W-1:0]  iidx;       // element index of the next patch read
  logic              p_rd_q;     // patch word arrives this cycle
  logic [IDX_W-1:0]  p_idx_q;    // element index of the arriving word

  // 2-entry output skid buffer
  logic [DATA_W-1:0] sb_patch  [2];
  logic [DATA_W-1:0] sb_weight [2];
  logic [IDX_W-1:0]  sb_idx    [2];
  logic              sb_rptr, sb_wptr;
  logic [1:0]        sb_cnt;
  logic              sb_pop;

  logic              kernel_rd, patch_rd, leave_stream;
  logic              hold_at_boundary;
  logic [2:0]        slots_used;

  assign sb_pop           = out_valid && out_ready;
  // A pending kernel only stops patch reads once the current patch is fully requested.
  assign hold_at_boundary = !kernel_fifo_empty && (iidx == '0);
  // Buffer slots still committed after this cycle's pop, counting the read in flight.
  assign slots_used       = {1'b0, sb_cnt} - {2'b00, sb_pop} + {2'b00, p_rd_q};

  // State register
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) state <= S_LOAD;
    else         state <= state_next;
  end

  // Next-state and FIFO read strobes
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path can infer a latch.
    state_next   = state;
    kernel_rd    = 1'b0;
    patch_rd     = 1'b0;
    leave_stream = 1'b0;
    case (state)
      S_LOAD: begin
        kernel_rd = !kernel_fifo_empty && (k_issued < LEN_IDX);
        if (k_rd_q && (kidx == LAST_IDX)) state_next = S_STREAM;
      end
      S_STREAM: begin
        patch_rd = kernel_loaded && !patch_fifo_empty && !hold_at_boundary &&
                   (slots_used < 3'd2);
        if (hold_at_boundary && (sb_cnt == 2'd0) && !p_rd_q) begin
          state_next   = S_LOAD;
          leave_stream = 1'b1;
        end
      end
      default: state_next = S_LOAD;
    endcase
  end

  // A read issued while reset is held would be lost, so strobes are masked by reset.
  assign kernel_fifo_rd_en = kernel_rd && !bus_rst;
  assign patch_fifo_rd_en  = patch_rd && !bus_rst;

  // Kernel load bookkeeping: read count, write index, loaded flag
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      k_rd_q        <= 1'b0;
      k_issued      <= '0;
      kidx          <= '0;
      kernel_loaded <= 1'b0;
    end else begin
      k_rd_q <= kernel_fifo_rd_en;
      if (kernel_fifo_rd_en) k_issued <= k_issued + 1'b1;
      if (k_rd_q) begin
        if (kidx == LAST_IDX) begin
          kidx          <= '0;
          kernel_loaded <= 1'b1;
        end else begin
          kidx <= kidx + 1'b1;
        end
      end
      if (leave_stream) begin
        kernel_loaded <= 1'b0;
        k_issued      <= '0;
      end
    end
  end

  // Weight bank write
  // NOTE: the bank is deliberately not reset; a full kernel load always precedes any read.
  always_ff @(posedge bus_clk) begin
    if (k_rd_q) bank[kidx] <= kernel_fifo_dout;
  end

  // Patch request index, tag pipeline, skid buffer and patch counter
  always_ff @(posedge bus_clk or posedge bus_rst) begin
    if (bus_rst) begin
      iidx        <= '0;
      p_rd_q      <= 1'b0;
      p_idx_q     <= '0;
      sb_rptr     <= 1'b0;
      sb_wptr     <= 1'b0;
      sb_cnt      <= 2'd0;
      patch_count <= '0;
      for (int i = 0; i < 2; i++) begin
        sb_patch[i]  <= '0;
        sb_weight[i] <= '0;
        sb_idx[i]    <= '0;
      end
    end else begin
      p_rd_q <= patch_fifo_rd_en;
      if (patch_fifo_rd_en) begin
        p_idx_q <= iidx;
        iidx    <= (iidx == LAST_IDX) ? '0 : iidx + 1'b1;
      end
      if (p_rd_q) begin
        sb_patch[sb_wptr]  <= patch_fifo_dout;
        sb_weight[sb_wptr] <= bank[p_idx_q];
        sb_idx[sb_wptr]    <= p_idx_q;
        sb_wptr            <= ~sb_wptr;
      end
      if (sb_pop) begin
        sb_rptr <= ~sb_rptr;
        if (sb_idx[sb_rptr] == LAST_IDX) patch_count <= patch_count + 1'b1;
      end
      sb_cnt <= sb_cnt + 2'(p_rd_q) - 2'(sb_pop);
    end
  end

  assign out_valid  = (sb_cnt != 2'd0);
  assign out_patch  = sb_patch[sb_rptr];
  assign out_weight = sb_weight[sb_rptr];
  assign out_index  = sb_idx[sb_rptr];
  assign out_last   = out_valid && (sb_idx[sb_rptr] == LAST_IDX);

endmodule

// File: tb/tb_patch_kernel_loader.sv
// Self-checking bench for patch_kernel_loader: behavioural FIFO models,
// an expected-pair queue built from the kernel/patch words pushed, and
// per-cycle protocol checks on the FIFO strobes and skid-buffer depth.
module tb_patch_kernel_loader;

  localparam int DW = 32;
  localparam int KL = 81;
  localparam int IW = 7;
  localparam int CW = 16;

  typedef struct packed {
    logic [DW-1:0] p;
    logic [DW-1:0] w;
    logic [IW-1:0] idx;
    logic          last;
  } pair_t;

  logic          bus_clk = 1'b0;
  logic          bus_rst = 1'b0;
  logic          kernel_fifo_rd_en, patch_fifo_rd_en;
  logic [DW-1:0] kernel_fifo_dout = '0, patch_fifo_dout = '0;
  logic          kernel_fifo_empty = 1'b1, patch_fifo_empty = 1'b1;
  logic          out_valid, out_last, kernel_loaded;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_patch, out_weight;
  logic [IW-1:0] out_index;
  logic [CW-1:0] patch_count;

  patch_kernel_loader #(.DATA_W(DW), .KERNEL_LEN(KL), .IDX_W(IW), .CNT_W(CW)) dut (
    .bus_clk(bus_clk), .bus_rst(bus_rst),
    .kernel_fifo_rd_en(kernel_fifo_rd_en), .kernel_fifo_dout(kernel_fifo_dout),
    .kernel_fifo_empty(kernel_fifo_empty),
    .patch_fifo_rd_en(patch_fifo_rd_en), .patch_fifo_dout(patch_fifo_dout),
    .patch_fifo_empty(patch_fifo_empty),
    .out_valid(out_valid), .out_ready(out_ready), .out_patch(out_patch),
    .out_weight(out_weight), .out_index(out_index), .out_last(out_last),
    .kernel_loaded(kernel_loaded), .patch_count(patch_count)
  );

  initial forever #5 bus_clk = ~bus_clk;

  logic [DW-1:0] kq[$];
  logic [DW-1:0] pq[$];
  pair_t         exp_q[$];

  int    n_checks = 0, n_fail = 0;
  int    cycle = 0, issued = 0, accepted = 0, hold_cnt = 0, hold_at = -1;
  int    first_rd_cycle = -1, first_valid_cycle = -1, last_acc_cycle = -1;
  bit    rand_ready = 1'b0, k_rd_prev = 1'b0, p_rd_prev = 1'b0;
  bit    stalled = 1'b0, saw_unload = 1'b0, reload_sent = 1'b0;
  pair_t prev_pair;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic push_kernel(input int base);
    for (int i = 0; i < KL; i++) kq.push_back(DW'(base + i));
  endtask

  // One patch of words; each expected pair carries the weight of the kernel it must use.
  task automatic push_patch(input int kbase, input bit rnd);
    pair_t e;
    for (int i = 0; i < KL; i++) begin
      e.p    = rnd ? DW'($urandom) : DW'(1000 + i);
      e.w    = DW'(kbase + i);
      e.idx  = IW'(i);
      e.last = (i == KL - 1);
      pq.push_back(e.p);
      exp_q.push_back(e);
    end
  endtask

  // One clock cycle: FIFO model update at the falling edge, then sampling and checks.
  task automatic step();
    pair_t cur, e;
    @(negedge bus_clk);
    if (k_rd_prev && kq.size() > 0) kernel_fifo_dout = kq.pop_front();
    if (p_rd_prev && pq.size() > 0) patch_fifo_dout  = pq.pop_front();
    kernel_fifo_empty = (kq.size() == 0);
    patch_fifo_empty  = (pq.size() == 0);
    if (hold_at >= 0 && exp_q.size() > 0 && int'(exp_q[0].idx) == hold_at) begin
      hold_cnt = 20;
      hold_at  = -1;
    end
    if (hold_cnt > 0) begin
      out_ready = 1'b0;
      hold_cnt--;
    end else begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
    #1;
    cycle++;
    cur = '{out_patch, out_weight, out_index, out_last};
    check("k_rd_while_empty", 128'(kernel_fifo_rd_en & kernel_fifo_empty), 128'(0));
    check("p_rd_while_empty", 128'(patch_fifo_rd_en & patch_fifo_empty), 128'(0));
    check("p_rd_unloaded", 128'(patch_fifo_rd_en & ~kernel_loaded), 128'(0));
    check("k_rd_in_stream", 128'(kernel_fifo_rd_en & kernel_loaded), 128'(0));
    check("buffered_gt2", 128'((issued - accepted) > 2), 128'(0));
    if (stalled) check("stall_stable", 128'({out_valid, cur}), 128'({1'b1, prev_pair}));
    if (!kernel_loaded) saw_unload = 1'b1;
    if (out_valid && first_valid_cycle < 0) first_valid_cycle = cycle;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("extra_pair", 128'(cur), 128'(0));
      end else begin
        e = exp_q.pop_front();
        check("pair", 128'(cur), 128'(e));
      end
      accepted++;
      last_acc_cycle = cycle;
    end
    stalled   = out_valid && !out_ready;
    prev_pair = cur;
    if (patch_fifo_rd_en) begin
      issued++;
      if (first_rd_cycle < 0) first_rd_cycle = cycle;
    end
    k_rd_prev = kernel_fifo_rd_en;
    p_rd_prev = patch_fifo_rd_en;
  endtask

  task automatic drain(input string tag, input int budget);
    int start;
    start = cycle;
    while (exp_q.size() > 0 && (cycle - start) < budget) step();
    check(tag, 128'(exp_q.size()), 128'(0));
    step();  // lets the final handshake land before counters are inspected
  endtask

  initial begin
    // Asynchronous reset: outputs clear before any clock edge.
    #2 bus_rst = 1'b1;
    #1;
    check("rst_valid", 128'(out_valid), 128'(0));
    check("rst_last", 128'(out_last), 128'(0));
    check("rst_loaded", 128'(kernel_loaded), 128'(0));
    check("rst_count", 128'(patch_count), 128'(0));
    check("rst_data", 128'({out_patch, out_weight, out_index}), 128'(0));
    check("rst_rd_en", 128'({kernel_fifo_rd_en, patch_fifo_rd_en}), 128'(0));
    repeat (2) @(negedge bus_clk);
    bus_rst = 1'b0;

    // Patch before kernel, then basic stream with out_ready held high.
    push_patch(100, 1'b0);
    repeat (20) step();
    check("pre_kernel_rd", 128'(patch_fifo_rd_en), 128'(0));
    check("pre_kernel_loaded", 128'(kernel_loaded), 128'(0));
    push_kernel(100);
    drain("basic_timeout", 400);
    check("basic_count", 128'(patch_count), 128'(1));
    check("basic_loaded", 128'(kernel_loaded), 128'(1));
    check("read_to_valid", 128'(first_valid_cycle - first_rd_cycle), 128'(2));
    check("throughput", 128'(last_acc_cycle - first_valid_cycle), 128'(KL - 1));

    // Backpressure: random ready plus a 20-cycle stall at element 40.
    rand_ready = 1'b1;
    hold_at    = 40;
    push_patch(100, 1'b1);
    drain("bp_timeout", 1000);
    check("bp_count", 128'(patch_count), 128'(2));

    // Reload: new kernel shows up at element 40 of the third patch.
    push_patch(100, 1'b1);
    saw_unload  = 1'b0;
    reload_sent = 1'b0;
    for (int c = 0; c < 1000 && !reload_sent; c++) begin
      step();
      if (exp_q.size() == KL - 41) begin
        push_kernel(200);
        push_patch(200, 1'b1);
        reload_sent = 1'b1;
      end
    end
    check("reload_sent", 128'(reload_sent), 128'(1));
    drain("reload_timeout", 2000);
    check("reload_count", 128'(patch_count), 128'(4));
    check("reload_unloaded", 128'(saw_unload), 128'(1));
    check("reload_loaded", 128'(kernel_loaded), 128'(1));

    // Mid-stream reset at element 50 of the fifth patch.
    push_patch(200, 1'b1);
    for (int c = 0; c < 1000; c++) begin
      if (exp_q.size() > 0 && exp_q[0].idx == IW'(50)) break;
      step();
    end
    check("midrst_reached", 128'(exp_q.size() > 0 && exp_q[0].idx == IW'(50)), 128'(1));
    bus_rst = 1'b1;
    #1;
    check("midrst_loaded", 128'(kernel_loaded), 128'(0));
    check("midrst_count", 128'(patch_count), 128'(0));
    check("midrst_valid", 128'(out_valid), 128'(0));
    kq.delete();
    pq.delete();
    exp_q.delete();
    k_rd_prev = 1'b0;
    p_rd_prev = 1'b0;
    stalled   = 1'b0;
    hold_cnt  = 0;
    issued    = 0;
    accepted  = 0;
    repeat (2) @(negedge bus_clk);
    bus_rst = 1'b0;

    // The old kernel is gone: patches wait until a full new kernel arrives.
    push_patch(300, 1'b1);
    repeat (15) step();
    check("post_rst_loaded", 128'(kernel_loaded), 128'(0));
    check("post_rst_pq", 128'(pq.size()), 128'(KL));
    push_kernel(300);
    drain("post_rst_timeout", 1000);
    check("post_rst_count", 128'(patch_count), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
